// File: rtl/memory_access_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_pkg
//
// Definitions shared by the memory-access stage and its load alignment
// sub-module:
//   - funct3 access size/sign codes (B, H, W, BU, HU)
//   - WB_MEM_SEL, the writeback-select value that marks a load
//   - FSM state encoding for the bus handshake
//   - store lane helpers (byte-enable mask and lane-replicated write data)
//
// Optional feature macro used by the stage: MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package memory_access_pkg;

    // Access size / sign codes carried in funct3.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Writeback select value meaning "result comes from data memory".
    localparam logic [1:0] WB_MEM_SEL = 2'b01;

    // Bus handshake states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Byte-enable mask for an access. Only funct3[1:0] carries the size, so
    // the unsigned load codes produce the same lane mask as their signed
    // counterparts.
    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so the byte enables alone pick
    // which lanes the memory actually writes.
    function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        logic [31:0] wdata;
        case (funct3[1:0])
            2'b00:   wdata = {4{data[7:0]}};
            2'b01:   wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

endpackage : memory_access_pkg

// File: rtl/memory_access_load_align.sv
// -----------------------------------------------------------------------------
// memory_access_load_align  (load_align sub-module of memory_access)
//
// Purely combinational load formatter: picks the addressed byte or halfword
// out of the 32-bit read word and sign- or zero-extends it according to
// funct3. Words pass through unchanged.
//
// Ports:
//   funct3   in   3   access size / sign code
//   addr_lo  in   2   low address bits selecting the lane
//   rdata    in  32   raw word returned by data memory
//   data     out 32   aligned and extended load result
// -----------------------------------------------------------------------------
module memory_access_load_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal written in an always_comb block gets a value on
    // every path (a default or a full case); a missed path infers a latch.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        // A halfword lane is chosen by addr_lo[1]; addr_lo[0] is ignored,
        // which truncates a misaligned halfword address.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'b0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'b0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule : memory_access_load_align

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//
// Memory stage of the pipeline. Issues loads and stores to a data memory with
// a req/ack handshake, stalls upstream while waiting for a slow ack, aborts
// an access that waits too long, and registers the writeback-stage values.
//
// Parameter:
//   ACK_TIMEOUT     BUSY cycles without dmem_ack before abort (1..255)
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined   - misaligned H/HU/W accesses issue no bus request, pulse
//               misalign_fault for one cycle and write a bubble
//   undefined - port misalign_fault absent; low address bits are truncated
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_in, rs2_in             effective address / ALU result, store data
//   funct3_in                  access size / sign
//   mem_write_in               store request
//   reg_write_in, rd_addr_in   destination write enable and register
//   wb_mux_in                  writeback select (WB_MEM_SEL marks a load)
//   pc_in                      instruction PC
//   dmem_req/we/addr/be/wdata  data memory request side
//   dmem_ack, dmem_rdata       data memory response (rdata valid with ack)
//   stall                      hold all upstream pipeline registers
//   forward_mem                combinational copy of alu_in for forwarding
//   *_wb                       registered writeback-stage values
//   bus_error                  one-cycle pulse after a timeout abort
//   misalign_fault             one-cycle pulse after a misaligned access
//                              (MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_in,
    input  logic [2:0]  funct3_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [1:0]  wb_mux_in,
    input  logic [31:0] pc_in,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,

    output logic        stall,
    output logic [31:0] forward_mem,

    output logic [4:0]  rd_addr_wb,
    output logic        reg_write_wb,
    output logic [1:0]  wb_mux_wb,
    output logic [31:0] alu_wb,
    output logic [31:0] load_wb,
    output logic [31:0] pc_wb,

`ifdef MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    output logic        bus_error
);

    // Timeout counter: 8 bits covers the full legal ACK_TIMEOUT range. The
    // abort fires in the BUSY cycle where the count would reach ACK_TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q,        state_d;
    logic [7:0]  cnt_q,          cnt_d;
    logic        bus_error_q,    bus_error_d;
    logic [4:0]  rd_addr_wb_q,   rd_addr_wb_d;
    logic        reg_write_wb_q, reg_write_wb_d;
    logic [1:0]  wb_mux_wb_q,    wb_mux_wb_d;
    logic [31:0] alu_wb_q,       alu_wb_d;
    logic [31:0] load_wb_q,      load_wb_d;
    logic [31:0] pc_wb_q,        pc_wb_d;

    // -------------------------------------------------------------------------
    // Access decode
    // -------------------------------------------------------------------------
    logic        mem_op;      // instruction is a load or a store
    logic        misalign;    // memory op with an illegal alignment (trapped)
    logic        access;      // memory op that goes to the bus
    logic        busy;
    logic        timeout;
    logic        req_int;
    logic        stall_int;
    logic [31:0] load_data;

    assign mem_op = mem_write_in | (wb_mux_in == WB_MEM_SEL);

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign misalign = mem_op &
                      ((((funct3_in == F3_H) || (funct3_in == F3_HU)) && alu_in[0]) ||
                       ((funct3_in == F3_W) && (alu_in[1:0] != 2'b00)));
    assign misalign_fault = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign access  = mem_op & ~misalign;
    assign busy    = (state_q == ST_BUSY);

    // A late ack in the final allowed cycle still completes the access.
    assign timeout = busy & ~dmem_ack & (cnt_q == TIMEOUT_LAST);

    // Upstream is frozen while BUSY, so the request fields below come
    // straight from the (held) inputs in both states.
    assign req_int   = busy | access;

    // The timeout cycle releases the stall so the aborted instruction leaves
    // the stage; otherwise the same access would re-issue from IDLE.
    assign stall_int = req_int & ~dmem_ack & ~timeout;

    // Reset forces the handshake quiet at once, even though the inputs may
    // still present an access while rst_n is low.
    assign dmem_req    = rst_n & req_int;
    assign stall       = rst_n & stall_int;
    assign dmem_we     = dmem_req & mem_write_in;
    assign dmem_addr   = {alu_in[31:2], 2'b00};
    assign dmem_be     = dmem_req ? store_be(funct3_in, alu_in[1:0]) : 4'b0000;
    assign dmem_wdata  = store_wdata(funct3_in, rs2_in);
    assign forward_mem = alu_in;

    // -------------------------------------------------------------------------
    // Load formatting
    // -------------------------------------------------------------------------
    memory_access_load_align u_load_align (
        .funct3  (funct3_in),
        .addr_lo (alu_in[1:0]),
        .rdata   (dmem_rdata),
        .data    (load_data)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access && !dmem_ack) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (dmem_ack || timeout) begin
                    state_d     = ST_IDLE;
                    bus_error_d = timeout;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Writeback fields always follow the inputs; only the write enable is
    // qualified. A stalled, aborted or trapped instruction becomes a bubble.
    always_comb begin
        rd_addr_wb_d   = rd_addr_in;
        wb_mux_wb_d    = wb_mux_in;
        alu_wb_d       = alu_in;
        pc_wb_d        = pc_in;
        load_wb_d      = load_data;
        reg_write_wb_d = reg_write_in & ~stall_int & ~timeout & ~misalign;
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign_d = misalign;
`endif

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    // NOTE: every flop here, including the wide writeback data, is reset: the
    // writeback outputs must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            bus_error_q    <= 1'b0;
            rd_addr_wb_q   <= '0;
            reg_write_wb_q <= 1'b0;
            wb_mux_wb_q    <= '0;
            alu_wb_q       <= '0;
            load_wb_q      <= '0;
            pc_wb_q        <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus_error_q    <= bus_error_d;
            rd_addr_wb_q   <= rd_addr_wb_d;
            reg_write_wb_q <= reg_write_wb_d;
            wb_mux_wb_q    <= wb_mux_wb_d;
            alu_wb_q       <= alu_wb_d;
            load_wb_q      <= load_wb_d;
            pc_wb_q        <= pc_wb_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q     <= misalign_d;
`endif
        end
    end

    assign bus_error    = bus_error_q;
    assign rd_addr_wb   = rd_addr_wb_q;
    assign reg_write_wb = reg_write_wb_q;
    assign wb_mux_wb    = wb_mux_wb_q;
    assign alu_wb       = alu_wb_q;
    assign load_wb      = load_wb_q;
    assign pc_wb        = pc_wb_q;

endmodule : memory_access

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
//
// Self-checking bench for memory_access (ACK_TIMEOUT = 4). Each instruction is
// described as a transaction; the expected bus fields, stall profile, load
// result and writeback values are computed from the transaction with plain
// arithmetic. Directed cases cover the documented scenarios, followed by a
// randomized run. With MISALIGN_TRAP_EN defined, the trap path is exercised.
// -----------------------------------------------------------------------------
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_in, rs2_in, pc_in, dmem_rdata;
    logic [2:0]  funct3_in;
    logic        mem_write_in, reg_write_in, dmem_ack;
    logic [4:0]  rd_addr_in;
    logic [1:0]  wb_mux_in;

    logic        dmem_req, dmem_we, stall, reg_write_wb, bus_error;
    logic [31:0] dmem_addr, dmem_wdata, forward_mem, alu_wb, load_wb, pc_wb;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_addr_wb;
    logic [1:0]  wb_mux_wb;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    memory_access #(.ACK_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_in       (alu_in),
        .rs2_in       (rs2_in),
        .funct3_in    (funct3_in),
        .mem_write_in (mem_write_in),
        .reg_write_in (reg_write_in),
        .rd_addr_in   (rd_addr_in),
        .wb_mux_in    (wb_mux_in),
        .pc_in        (pc_in),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .stall        (stall),
        .forward_mem  (forward_mem),
        .rd_addr_wb   (rd_addr_wb),
        .reg_write_wb (reg_write_wb),
        .wb_mux_wb    (wb_mux_wb),
        .alu_wb       (alu_wb),
        .load_wb      (load_wb),
        .pc_wb        (pc_wb),
`ifdef MISALIGN_TRAP_EN
        .misalign_fault (misalign_fault),
`endif
        .bus_error    (bus_error)
    );

    typedef struct {
        logic [2:0]  f3;
        bit          st;
        bit          ld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          regw;
        logic [1:0]  wbm;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          ack_dly;   // cycles after issue until ack (> TO: never)
    } txn_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] sh, v;
        case (f3)
            3'b000, 3'b100: begin
                sh = (a % 4) * 8;
                v  = (w >> sh) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'h80) v = v - 32'h100;
            end
            3'b001, 3'b101: begin
                sh = ((a % 4) / 2) * 16;
                v  = (w >> sh) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] m;
        case (f3)
            3'b000:  m = 32'h1 << (a % 4);
            3'b001:  m = 32'h3 << ((a % 4) & 32'h2);
            default: m = 32'hF;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return (d & 32'hFF) * 32'h01010101;
            3'b001:  return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic txn_t mk(input logic [2:0] f3, input bit st, input bit ld,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] rdata, input int ack_dly);
        txn_t t;
        t.f3 = f3; t.st = st; t.ld = ld; t.addr = addr; t.data = data;
        t.rdata = rdata; t.ack_dly = ack_dly;
        t.rd = 5'($urandom_range(1, 31));
        t.pc = $urandom() & 32'hFFFF_FFFC;
        t.regw = ld;
        t.wbm = ld ? WB_MEM_SEL : 2'b00;
        return t;
    endfunction

    task automatic drive_nop();
        alu_in = '0; rs2_in = '0; funct3_in = '0; mem_write_in = 1'b0;
        reg_write_in = 1'b0; rd_addr_in = '0; wb_mux_in = 2'b00; pc_in = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    // Runs one instruction through the stage. Called just after a rising edge.
    task automatic run_txn(input txn_t t);
        bit access;
        bit tmo;
        int last;
        access = t.st || t.ld;
        tmo    = access && (t.ack_dly > TO);
        if (!access)          last = 0;
        else if (!tmo)        last = t.ack_dly;
        else                  last = TO;

        alu_in = t.addr; rs2_in = t.data; funct3_in = t.f3; mem_write_in = t.st;
        reg_write_in = t.regw; rd_addr_in = t.rd; wb_mux_in = t.wbm; pc_in = t.pc;

        for (int k = 0; k <= last; k++) begin
            dmem_ack   = access && (k == t.ack_dly);
            dmem_rdata = (k == t.ack_dly) ? t.rdata : $urandom();
            #2;
            if (k > 0) begin
                check("bubble_regw", 32'(reg_write_wb), 32'd0);
                check("bus_err_quiet", 32'(bus_error), 32'd0);
            end
            check("stall", 32'(stall), 32'(k < last));
            check("req", 32'(dmem_req), 32'(access));
            check("we", 32'(dmem_we), 32'(access && t.st));
            check("fwd", forward_mem, t.addr);
            if (access) check("addr", dmem_addr, t.addr & 32'hFFFF_FFFC);
            if (t.st) begin
                check("be", 32'(dmem_be), ref_be(t.f3, t.addr));
                check("wdata", dmem_wdata, ref_wdata(t.f3, t.data));
            end
            @(posedge clk);
            #1;
        end

        check("regw_wb", 32'(reg_write_wb), 32'(t.regw && !tmo));
        check("bus_error", 32'(bus_error), 32'(tmo));
        if (!tmo) begin
            check("rd_wb", 32'(rd_addr_wb), 32'(t.rd));
            check("pc_wb", pc_wb, t.pc);
            check("alu_wb", alu_wb, t.addr);
            check("wbmux_wb", 32'(wb_mux_wb), 32'(t.wbm));
            if (t.ld) check("load_wb", load_wb, ref_load(t.f3, t.addr, t.rdata));
        end
        drive_nop();
        #1;
        if (tmo) begin
            check("req_drop", 32'(dmem_req), 32'd0);
            check("stall_drop", 32'(stall), 32'd0);
        end
        #1;
    endtask

    initial begin
        txn_t t;
        int kind;
        logic [2:0] ld_codes [5];
        ld_codes[0] = F3_B; ld_codes[1] = F3_H; ld_codes[2] = F3_W;
        ld_codes[3] = F3_BU; ld_codes[4] = F3_HU;

        // Reset with an access already presented at the inputs.
        drive_nop();
        rst_n = 1'b0;
        alu_in = 32'h200; funct3_in = F3_W; wb_mux_in = WB_MEM_SEL; reg_write_in = 1'b1;
        #12;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_regw_wb", 32'(reg_write_wb), 32'd0);
        check("rst_rd_wb", 32'(rd_addr_wb), 32'd0);
        check("rst_load_wb", load_wb, 32'd0);
        check("rst_alu_wb", alu_wb, 32'd0);
        check("rst_pc_wb", pc_wb, 32'd0);
        drive_nop();
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SW 0x100, ack same cycle.
        run_txn(mk(F3_W, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0));
        // LB 0x103, ack three cycles after issue.
        run_txn(mk(F3_B, 1'b0, 1'b1, 32'h103, 32'h0, 32'h8000_0000, 3));
        // LHU 0x102 and SH 0x102.
        run_txn(mk(F3_HU, 1'b0, 1'b1, 32'h102, 32'h0, 32'h8001_0000, 1));
        run_txn(mk(F3_H, 1'b1, 1'b0, 32'h102, 32'h1234, 32'h0, 0));
        // No ack: abort after TO BUSY cycles.
        run_txn(mk(F3_W, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 100));
        // Ack in the timeout cycle completes normally.
        run_txn(mk(F3_H, 1'b0, 1'b1, 32'h46, 32'h0, 32'h0000_F00D, TO));
        // Plain ALU instruction passes straight through.
        t = mk(F3_H, 1'b0, 1'b0, 32'h1235, 32'h0, 32'h0, 0);
        t.regw = 1'b1; t.wbm = 2'b10;
        run_txn(t);

        // Reset asserted while BUSY.
        alu_in = 32'h300; funct3_in = F3_W; wb_mux_in = WB_MEM_SEL; reg_write_in = 1'b1;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        check("busy_stall", 32'(stall), 32'd1);
        check("busy_req", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstbusy_req", 32'(dmem_req), 32'd0);
        check("rstbusy_stall", 32'(stall), 32'd0);
        check("rstbusy_regw", 32'(reg_write_wb), 32'd0);
        drive_nop();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_txn(mk(F3_W, 1'b0, 1'b1, 32'h304, 32'h0, 32'h1357_9BDF, 0));
        run_txn(mk(F3_B, 1'b0, 1'b1, 32'h305, 32'h0, 32'h0000_7F00, 2));

`ifdef MISALIGN_TRAP_EN
        // LW 0x101 traps: no request, fault pulse, bubble.
        alu_in = 32'h101; funct3_in = F3_W; wb_mux_in = WB_MEM_SEL; reg_write_in = 1'b1;
        rd_addr_in = 5'd7; dmem_ack = 1'b1;
        #2;
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("mis_fault", 32'(misalign_fault), 32'd1);
        check("mis_regw", 32'(reg_write_wb), 32'd0);
        drive_nop();
        @(posedge clk);
        #1;
        check("mis_fault_end", 32'(misalign_fault), 32'd0);
`endif

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                t = mk(3'($urandom_range(0, 7)), 1'b0, 1'b0, $urandom(), 32'h0, 32'h0, 0);
                t.regw = 1'($urandom_range(0, 1));
                t.wbm  = (t.regw) ? 2'b10 : 2'b00;
            end else if (kind == 1) begin
                t = mk(ld_codes[$urandom_range(0, 4)], 1'b0, 1'b1, $urandom(), 32'h0,
                       $urandom(), ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, 5));
            end else begin
                t = mk(3'($urandom_range(0, 2)), 1'b1, 1'b0, $urandom(), $urandom(),
                       32'h0, ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, 5));
            end
`ifdef MISALIGN_TRAP_EN
            if (t.st || t.ld) begin
                if (t.f3[1:0] == 2'b01) t.addr[0] = 1'b0;
                if (t.f3[1:0] == 2'b10) t.addr[1:0] = 2'b00;
            end
`endif
            run_txn(t);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_memory_access
